booth_op_sequencer: RTL and testbench
=====================================

Name: booth_op_sequencer

Overview:
- Upstream issue stage for the radix-4 Booth multiplier (`booth`).
- Accepts signed operand pairs over a valid/ready stream and buffers them in a small FIFO.
- Drives the multiplier's start/M/Q inputs one operation at a time, captures `ans` after a fixed latency, and presents it on a valid/ready result stream.
- Converts the multiplier's bare one-cycle start pulse and fixed-latency protocol into a back-pressurable pipeline stage.

Parameters:
- N, 8: operand width; result width is 2N.
- LAT, 6: cycles from the first rising edge at which the multiplier samples mul_start=1 to the edge at which mul_ans is valid. Must be >= 1.
- DEPTH, 4: operand FIFO entries. Power of two, >= 2.

Ports:
- clk_100MHz  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept a pair.
- in_m  in  N  multiplicand, two's complement.
- in_q  in  N  multiplier, two's complement.
- mul_start  out  1  one-cycle start pulse to the Booth multiplier.
- mul_m  out  N  multiplicand to the multiplier.
- mul_q  out  N  multiplier operand to the multiplier.
- mul_ans  in  2N  product from the multiplier.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_ans  out  2N  captured product.
- busy  out  1  FSM not in IDLE.
- fifo_count  out  $clog2(DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset is asynchronous and active-low; one clock, clk_100MHz.
- On rst_n=0, immediately and regardless of state:
  - mul_start=0, out_valid=0, busy=0.
  - mul_m, mul_q, out_ans = 0.
  - FIFO emptied; fifo_count=0; in_ready=0 while rst_n=0, 1 after release.
  - FSM returns to IDLE; an in-flight op is discarded.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready = (fifo_count != DEPTH). A full FIFO refuses a push even if a pop occurs in the same cycle.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves fifo_count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, LAUNCH, WAIT, HOLD.
  - IDLE: if FIFO non-empty, pop the head into mul_m/mul_q → LAUNCH.
  - LAUNCH: mul_start=1 for exactly this cycle; latency counter cleared → WAIT.
  - WAIT: counter increments each cycle. On the cycle where counter == LAT-1, out_ans <= mul_ans and out_valid <= 1 → HOLD. mul_start=0.
  - HOLD: out_valid and out_ans held stable until out_ready. On out_valid && out_ready:
    - FIFO non-empty: pop the next pair and go directly to LAUNCH; out_valid drops the same edge.
    - FIFO empty: → IDLE.
- Timing: the result edge lands exactly LAT edges after the edge that closes the mul_start-high cycle.
- mul_m/mul_q change only on a pop and are stable from LAUNCH through HOLD; the multiplier may resample them.
- Only one op in flight; mul_start never asserts while out_valid=1.
- No arithmetic is done here. Products pass verbatim, signed 2N-bit.

Optional Feature:
- Macro: BOOTH_OPERAND_ECHO_EN.
- Defined: adds output ports out_m[N] and out_q[N]. They carry the operands of the current out_ans, are captured with out_ans, reset to 0, and are stable while out_valid=1.
- Undefined: ports absent; no extra registers.

Decomposition:
- Shared package booth_pkg:
  - default N, LAT, DEPTH localparams;
  - FSM state encoding (2-bit enum: IDLE, LAUNCH, WAIT, HOLD);
  - count-width function.
- One natural sub-module: booth_op_fifo (DEPTH x 2N storage, push/pop, count, full/empty). The FSM and capture logic stay in the top module.

Test Plan:
- Single op: in_m=8'h07, in_q=8'hFA, with a behavioural multiplier model of latency LAT=6 → one mul_start pulse; out_valid rises exactly 6 edges after the start cycle; out_ans=16'hFFD6.
- Extremes: 8'h80×8'h80 → 16'h4000; 8'h7F×8'h80 → 16'hC080; 8'h00×8'hFF → 16'h0000. All in order.
- Fill: out_ready=0, push 6 pairs back-to-back → 1 launched, 4 buffered; in_ready=0 when fifo_count=4; pair 6 stalls until the first result is taken.
- Backpressure: hold out_ready=0 for 20 cycles in HOLD → out_valid=1 and out_ans stable; no mul_start. Release → next LAUNCH on the handshake edge, with no IDLE cycle.
- Reset mid-WAIT: drop rst_n for 2 ns between edges → all outputs 0 asynchronously; after release fifo_count=0 and the aborted result never appears.
- With BOOTH_OPERAND_ECHO_EN: 8'h07×8'hFA → out_m=8'h07, out_q=8'hFA alongside out_ans=16'hFFD6.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth operand sequencer: default sizes, FSM encoding and the FIFO count-width helper.
package booth_pkg;

    localparam int N_DEF     = 8;
    localparam int LAT_DEF   = 6;
    localparam int DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/booth_op_sequencer_if.sv
// Operand stream, multiplier hookup and result stream of the Booth operand sequencer.
// BOOTH_OPERAND_ECHO_EN adds the out_m/out_q operand echo signals.
interface booth_op_sequencer_if #(parameter int N = 8);

    logic                  in_valid;
    logic                  in_ready;
    logic signed [N-1:0]   in_m;
    logic signed [N-1:0]   in_q;

    logic                  mul_start;
    logic signed [N-1:0]   mul_m;
    logic signed [N-1:0]   mul_q;
    logic signed [2*N-1:0] mul_ans;

    logic                  out_valid;
    logic                  out_ready;
    logic signed [2*N-1:0] out_ans;
`ifdef BOOTH_OPERAND_ECHO_EN
    logic signed [N-1:0]   out_m;
    logic signed [N-1:0]   out_q;
`endif

    modport master (
        input  in_valid, in_m, in_q, mul_ans, out_ready,
        output in_ready, mul_start, mul_m, mul_q, out_valid, out_ans
`ifdef BOOTH_OPERAND_ECHO_EN
        , output out_m, out_q
`endif
    );

    modport slave (
        output in_valid, in_m, in_q, mul_ans, out_ready,
        input  in_ready, mul_start, mul_m, mul_q, out_valid, out_ans
`ifdef BOOTH_OPERAND_ECHO_EN
        , input out_m, out_q
`endif
    );

endinterface

// File: rtl/booth_op_fifo.sv
// Operand-pair FIFO: DEPTH entries of W bits, first-word fall-through read, occupancy count.
module booth_op_fifo
    import booth_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [W-1:0]            wdata,
    output logic [W-1:0]            rdata,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A full FIFO refuses a push even when a pop frees a slot the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/booth_op_sequencer.sv
// Issue stage for the radix-4 Booth multiplier: buffers operand pairs, launches one op at a time,
// captures the product after LAT cycles and holds it on a valid/ready stream. Option: BOOTH_OPERAND_ECHO_EN.
module booth_op_sequencer
    import booth_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int LAT   = LAT_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                    clk_100MHz,
    input  logic                    rst_n,
    booth_op_sequencer_if.master    bus,
    output logic                    busy,
    output logic [cnt_w(DEPTH)-1:0] fifo_count
);

    localparam int LW = (LAT > 1) ? $clog2(LAT) : 1;

    state_t                state;
    state_t                state_next;
    logic [LW-1:0]         lat_cnt;
    logic                  pop;
    logic                  cap;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [2*N-1:0]        head;
    logic signed [N-1:0]   op_m;
    logic signed [N-1:0]   op_q;
    logic signed [2*N-1:0] ans;

    booth_op_fifo #(.W(2*N), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk_100MHz),
        .rst_n (rst_n),
        .push  (bus.in_valid),
        .pop   (pop),
        .wdata ({bus.in_m, bus.in_q}),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        cap        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: state_next = WAIT;
            WAIT: begin
                if (lat_cnt == LW'(LAT - 1)) begin
                    cap        = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                // Chain straight into the next launch so no IDLE bubble appears between ops.
                if (bus.out_ready) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = LAUNCH;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lat_cnt <= '0;
            op_m    <= '0;
            op_q    <= '0;
            ans     <= '0;
        end else begin
            state <= state_next;
            if (state == LAUNCH)    lat_cnt <= '0;
            else if (state == WAIT) lat_cnt <= lat_cnt + 1'b1;
            if (pop) begin
                op_m <= head[2*N-1:N];
                op_q <= head[N-1:0];
            end
            if (cap) ans <= bus.mul_ans;
        end
    end

`ifdef BOOTH_OPERAND_ECHO_EN
    logic signed [N-1:0] echo_m;
    logic signed [N-1:0] echo_q;

    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            echo_m <= '0;
            echo_q <= '0;
        end else if (cap) begin
            echo_m <= op_m;
            echo_q <= op_q;
        end
    end

    assign bus.out_m = echo_m;
    assign bus.out_q = echo_q;
`endif

    // Handshake flags decode directly from state so reset clears them without a clock.
    assign bus.in_ready  = rst_n && !fifo_full;
    assign bus.mul_start = (state == LAUNCH);
    assign bus.mul_m     = op_m;
    assign bus.mul_q     = op_q;
    assign bus.out_valid = (state == HOLD);
    assign bus.out_ans   = ans;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_booth_op_sequencer.sv
// Scoreboard bench for booth_op_sequencer with a fixed-latency multiplier model that outputs junk off-window.
module tb_booth_op_sequencer;
    import booth_pkg::*;

    localparam int N     = 8;
    localparam int LAT   = 6;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam logic [2*N-1:0] JUNK = 16'hDEAD;

    typedef struct {
        logic [N-1:0]   m;
        logic [N-1:0]   q;
        logic [2*N-1:0] ans;
    } exp_t;

    logic          clk_100MHz = 1'b0;
    logic          rst_n      = 1'b0;
    logic          busy;
    logic [CW-1:0] fifo_count;

    booth_op_sequencer_if #(.N(N)) bus();

    booth_op_sequencer #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .bus        (bus),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // Multiplier model: the product is valid only when sampled LAT edges after start is seen.
    logic signed [2*N-1:0] prod;
    logic signed [2*N-1:0] pipe [LAT];
    assign prod        = bus.mul_m * bus.mul_q;
    assign bus.mul_ans = pipe[LAT-1];

    always @(posedge clk_100MHz) begin
        pipe[0] <= bus.mul_start ? prod : JUNK;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   start_edge = -100;
    int   n_starts = 0;
    bit   mon_en   = 1'b0;
    logic prev_valid = 1'b0;
    logic prev_hs    = 1'b0;
    logic [2*N-1:0] prev_ans = '0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_100MHz) cyc++;

    // Monitor: pops the scoreboard on each result handshake, checks latency and hold stability.
    always @(negedge clk_100MHz) begin
        if (mon_en && rst_n) begin
            if (bus.mul_start) begin
                check("start_while_valid", 16'(bus.out_valid), 16'd0);
                start_edge = cyc + 1;
                n_starts++;
            end
            if (bus.out_valid && !prev_valid)
                check("latency", 16'(cyc - start_edge), 16'(LAT));
            if (prev_valid && !prev_hs) begin
                check("hold_valid", 16'(bus.out_valid), 16'd1);
                check("hold_ans", $unsigned(bus.out_ans), prev_ans);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %h, expected none", $unsigned(bus.out_ans));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_ans", $unsigned(bus.out_ans), e.ans);
`ifdef BOOTH_OPERAND_ECHO_EN
                    check("out_m", 16'($unsigned(bus.out_m)), 16'(e.m));
                    check("out_q", 16'($unsigned(bus.out_q)), 16'(e.q));
`endif
                end
            end
            prev_valid = bus.out_valid;
            prev_hs    = bus.out_valid && bus.out_ready;
            prev_ans   = $unsigned(bus.out_ans);
        end
    end

    task automatic push(input logic [N-1:0] m, input logic [N-1:0] q, input logic [2*N-1:0] ans);
        int n;
        n = 0;
        sb.push_back('{m, q, ans});
        bus.in_valid = 1'b1;
        bus.in_m     = m;
        bus.in_q     = q;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk_100MHz); #1;
            n++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: got in_ready=0, expected 1");
        end
        @(posedge clk_100MHz); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            @(posedge clk_100MHz); #1;
            n++;
        end
        check("drain", 16'(sb.size() != 0 || busy), 16'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mul_start"}, 16'(bus.mul_start), 16'd0);
        check({tag, "_out_valid"}, 16'(bus.out_valid), 16'd0);
        check({tag, "_busy"},      16'(busy),          16'd0);
        check({tag, "_mul_m"},     16'($unsigned(bus.mul_m)), 16'd0);
        check({tag, "_mul_q"},     16'($unsigned(bus.mul_q)), 16'd0);
        check({tag, "_out_ans"},   $unsigned(bus.out_ans),   16'd0);
        check({tag, "_count"},     16'(fifo_count),    16'd0);
        check({tag, "_in_ready"},  16'(bus.in_ready),  16'd0);
`ifdef BOOTH_OPERAND_ECHO_EN
        check({tag, "_out_m"},     16'($unsigned(bus.out_m)), 16'd0);
        check({tag, "_out_q"},     16'($unsigned(bus.out_q)), 16'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s0;
        bus.in_valid  = 1'b0;
        bus.in_m      = '0;
        bus.in_q      = '0;
        bus.out_ready = 1'b0;
        #3;
        check_reset_outputs("por");
        @(posedge clk_100MHz); @(posedge clk_100MHz); #1;
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 16'(bus.in_ready), 16'd1);
        check("rel_count",    16'(fifo_count),   16'd0);
        mon_en = 1'b1;
        @(posedge clk_100MHz); #1;

        // Single op
        bus.out_ready = 1'b1;
        s0 = n_starts;
        push(8'h07, 8'hFA, 16'hFFD6);
        wait_drain(60);
        check("single_starts", 16'(n_starts - s0), 16'd1);

        // Extremes, in order
        push(8'h80, 8'h80, 16'h4000);
        push(8'h7F, 8'h80, 16'hC080);
        push(8'h00, 8'hFF, 16'h0000);
        wait_drain(120);

        // Fill with the consumer stalled, then long backpressure in HOLD
        bus.out_ready = 1'b0;
        push(8'h03, 8'h05, 16'h000F);
        push(8'hFF, 8'hFF, 16'h0001);
        push(8'hFE, 8'h05, 16'hFFF6);
        push(8'h7F, 8'h7F, 16'h3F01);
        push(8'h01, 8'h81, 16'hFF81);
        check("full_count",    16'(fifo_count),   16'd4);
        check("full_in_ready", 16'(bus.in_ready), 16'd0);
        fork
            push(8'h02, 8'h80, 16'hFF00);
        join_none
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk_100MHz); #1;
            n++;
        end
        check("hold_reached", 16'(bus.out_valid), 16'd1);
        s0 = n_starts;
        repeat (20) @(posedge clk_100MHz);
        #1;
        check("bp_no_start",   16'(n_starts - s0), 16'd0);
        check("bp_count",      16'(fifo_count),    16'd4);
        check("bp_in_ready",   16'(bus.in_ready),  16'd0);
        bus.out_ready = 1'b1;
        @(posedge clk_100MHz); #1;
        check("chain_launch",  16'(bus.mul_start), 16'd1);
        check("chain_valid",   16'(bus.out_valid), 16'd0);
        wait_drain(200);

        // Asynchronous reset while an op sits in WAIT
        push(8'h05, 8'h05, 16'h0019);
        n = 0;
        while (!bus.mul_start && n < 20) begin
            @(posedge clk_100MHz); #1;
            n++;
        end
        @(posedge clk_100MHz); #1;
        @(posedge clk_100MHz); #1;
        check("pre_rst_busy", 16'(busy), 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        sb.delete();
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
        #1;
        rst_n = 1'b1;
        repeat (LAT + 4) @(posedge clk_100MHz);
        #1;
        check("post_rst_count", 16'(fifo_count), 16'd0);
        check("post_rst_busy",  16'(busy),       16'd0);
        check("post_rst_ready", 16'(bus.in_ready), 16'd1);

        // Recovery after the aborted op
        push(8'h07, 8'hFA, 16'hFFD6);
        push(8'h80, 8'h7F, 16'hC080);
        wait_drain(80);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
